// File: rtl/aud_i2c_pkg.sv
// Shared types and constants for the WM8731 control-port I2C responder.
// The register indices follow the codec's own register map.
package aud_i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_BYTE1     = 3'd3,
        S_ACK1      = 3'd4,
        S_BYTE2     = 3'd5,
        S_ACK2      = 3'd6,
        S_WAIT_STOP = 3'd7
    } state_t;

    localparam logic [6:0] WM8731_ADDR = 7'b0011010;

    localparam logic [6:0] LEFT_LINE_IN  = 7'd0;
    localparam logic [6:0] RIGHT_LINE_IN = 7'd1;
    localparam logic [6:0] LEFT_HP_OUT   = 7'd2;
    localparam logic [6:0] RIGHT_HP_OUT  = 7'd3;
    localparam logic [6:0] ANALOG_PATH   = 7'd4;
    localparam logic [6:0] DIGITAL_PATH  = 7'd5;
    localparam logic [6:0] POWER_DOWN    = 7'd6;
    localparam logic [6:0] DIGITAL_IF    = 7'd7;
    localparam logic [6:0] SAMPLING      = 7'd8;
    localparam logic [6:0] ACTIVE        = 7'd9;
    localparam logic [6:0] RESET         = 7'd15;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings the asynchronous SCL/SDA pins into the system clock domain and
// derives single-cycle edge, START and STOP strobes from the synchronized lines.
module i2c_line_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    // Bit 0 = metastability flop, bit 1 = synchronized level, bit 2 = previous level.
    logic [2:0] scl_pipe_q, scl_pipe_d;
    logic [2:0] sda_pipe_q, sda_pipe_d;

    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], i_scl};
        sda_pipe_d = {sda_pipe_q[1:0], i_sda};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_pipe_q <= 3'b111;
            sda_pipe_q <= 3'b111;
        end else begin
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
        end
    end

    logic scl_high;
    assign scl_high  = scl_pipe_q[1] & scl_pipe_q[2];

    assign scl_rise  = scl_pipe_q[1] & ~scl_pipe_q[2];
    assign scl_fall  = ~scl_pipe_q[1] & scl_pipe_q[2];
    assign start_det = scl_high & sda_pipe_q[2] & ~sda_pipe_q[1];
    assign stop_det  = scl_high & ~sda_pipe_q[2] & sda_pipe_q[1];
    assign sda_s     = sda_pipe_q[1];

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C write-only target modelling the WM8731 control port: ACKs 3-byte frames,
// commits them to a 9-bit register shadow and flags protocol errors.
module i2c_codec_responder
    import aud_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = WM8731_ADDR,
    parameter int         NUM_REGS = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oen,
    output logic       o_wr_valid,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_err,
    output logic       o_busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_line_sync u_line_sync (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_scl     (i_scl),
        .i_sda     (i_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte1_q, byte1_d;
    logic       match_q, match_d;
    logic       oen_q, oen_d;
    logic       wr_valid_q, wr_valid_d;
    logic       err_q, err_d;
    logic [6:0] reg_addr_q, reg_addr_d;
    logic [8:0] reg_data_q, reg_data_d;
    logic [8:0] rd_data_q, rd_data_d;
    logic [8:0] shadow_q [NUM_REGS];
    logic       commit;
    logic       in_frame;

    assign in_frame = (state_q != S_IDLE) && (state_q != S_WAIT_STOP);

    // In byte states bit_cnt counts latched bits; in ACK states it marks that
    // the ninth SCL pulse has risen, so the following fall ends the ACK slot.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte1_d    = byte1_q;
        match_d    = match_q;
        oen_d      = oen_q;
        wr_valid_d = 1'b0;
        err_d      = 1'b0;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        commit     = 1'b0;

        if (start_det) begin
            err_d     = in_frame;
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            oen_d     = 1'b0;
        end else if (stop_det) begin
            err_d     = in_frame;
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            oen_d     = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_BYTE1, S_BYTE2: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == S_ADDR) begin
                            match_d = (shift_q[7:1] == DEV_ADDR) && !shift_q[0];
                            oen_d   = (shift_q[7:1] == DEV_ADDR) && !shift_q[0];
                            state_d = S_ADDR_ACK;
                        end else if (state_q == S_BYTE1) begin
                            byte1_d = shift_q;
                            oen_d   = 1'b1;
                            state_d = S_ACK1;
                        end else begin
                            oen_d   = 1'b1;
                            state_d = S_ACK2;
                        end
                    end
                end
                S_ADDR_ACK, S_ACK1, S_ACK2: begin
                    if (scl_rise) begin
                        bit_cnt_d = 4'd1;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        bit_cnt_d = 4'd0;
                        oen_d     = 1'b0;
                        if (state_q == S_ADDR_ACK) begin
                            state_d = match_q ? S_BYTE1 : S_WAIT_STOP;
                        end else if (state_q == S_ACK1) begin
                            state_d = S_BYTE2;
                        end else begin
                            commit     = 1'b1;
                            wr_valid_d = 1'b1;
                            reg_addr_d = byte1_q[7:1];
                            reg_data_d = {byte1_q[0], shift_q};
                            state_d    = S_WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            byte1_q    <= 8'd0;
            match_q    <= 1'b0;
            oen_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;
            reg_addr_q <= 7'd0;
            reg_data_q <= 9'd0;
            rd_data_q  <= 9'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte1_q    <= byte1_d;
            match_q    <= match_d;
            oen_q      <= oen_d;
            wr_valid_q <= wr_valid_d;
            err_q      <= err_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Out-of-range register indices decode to no write enable at all.
    logic [NUM_REGS-1:0] shadow_we;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_shadow_we
            assign shadow_we[gi] = commit && (byte1_q[7:1] == 7'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rst) begin
                shadow_q[i] <= 9'd0;
            end else if (shadow_we[i]) begin
                shadow_q[i] <= {byte1_q[0], shift_q};
            end
        end
    end

    always_comb begin
        rd_data_d = 9'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_addr == 4'(i)) begin
                rd_data_d = shadow_q[i];
            end
        end
    end

    assign o_sda_oen  = oen_q;
    assign o_wr_valid = wr_valid_q;
    assign o_reg_addr = reg_addr_q;
    assign o_reg_data = reg_data_q;
    assign o_rd_data  = rd_data_q;
    assign o_err      = err_q;
    assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for the WM8731 control-port responder: an I2C master model
// drives frames on an open-drain SDA bus and each scenario checks its own results.
module tb_i2c_codec_responder;
    import aud_i2c_pkg::*;

    logic       clk;
    logic       i_rst;
    logic       m_scl;
    logic       m_sda;
    logic       bus_sda;
    logic       o_sda_oen;
    logic       o_wr_valid;
    logic [6:0] o_reg_addr;
    logic [8:0] o_reg_data;
    logic [3:0] i_rd_addr;
    logic [8:0] o_rd_data;
    logic       o_err;
    logic       o_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    int         wr_cnt     = 0;
    int         err_cnt    = 0;
    int         oen_rises  = 0;
    logic       oen_prev   = 1'b0;

    assign bus_sda = m_sda & ~o_sda_oen;

    i2c_codec_responder dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_scl      (m_scl),
        .i_sda      (bus_sda),
        .o_sda_oen  (o_sda_oen),
        .o_wr_valid (o_wr_valid),
        .o_reg_addr (o_reg_addr),
        .o_reg_data (o_reg_data),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_err      (o_err),
        .o_busy     (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (o_wr_valid) wr_cnt = wr_cnt + 1;
        if (o_err) err_cnt = err_cnt + 1;
        if (o_sda_oen && !oen_prev) oen_rises = oen_rises + 1;
        oen_prev = o_sda_oen;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        wait_clk(8);
        m_scl = 1'b1;
        wait_clk(8);
        m_sda = 1'b0;
        wait_clk(8);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        wait_clk(8);
        m_scl = 1'b1;
        wait_clk(8);
        m_sda = 1'b1;
        wait_clk(16);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(8);
        m_sda = b;
        wait_clk(8);
        m_scl = 1'b1;
        wait_clk(16);
        m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wait_clk(8);
        m_sda = 1'b1;
        wait_clk(8);
        m_scl = 1'b1;
        wait_clk(8);
        ack = o_sda_oen & ~bus_sda;
        wait_clk(8);
        m_scl = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, output logic [2:0] acks);
        i2c_start();
        send_byte(b0, acks[2]);
        send_byte(b1, acks[1]);
        send_byte(b2, acks[0]);
        i2c_stop();
    endtask

    task automatic rd(input logic [3:0] idx, output logic [8:0] val);
        @(negedge clk);
        i_rd_addr = idx;
        @(negedge clk);
        val = o_rd_data;
    endtask

    task automatic test_reset();
        logic [8:0] v;
        i_rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; i_rd_addr = 4'd0;
        wait_clk(4);
        i_rst = 1'b0;
        wait_clk(2);
        tests_run++; if (o_sda_oen !== 1'b0) begin tests_failed++; $display("FAIL reset_oen: got %b expected 0", o_sda_oen); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        tests_run++; if (o_wr_valid !== 1'b0 || o_err !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: got wr=%b err=%b expected 0 0", o_wr_valid, o_err); end
        tests_run++; if (o_reg_addr !== 7'h00 || o_reg_data !== 9'h000) begin tests_failed++; $display("FAIL reset_regout: got %h/%h expected 00/000", o_reg_addr, o_reg_data); end
        rd(4'd4, v);
        tests_run++; if (v !== 9'h000) begin tests_failed++; $display("FAIL reset_shadow4: got %h expected 000", v); end
        $display("[TB] reset checked");
    endtask

    task automatic test_write();
        logic [2:0] acks;
        logic [8:0] v;
        int w0, e0, o0;
        w0 = wr_cnt; e0 = err_cnt; o0 = oen_rises;
        send_frame(8'h34, 8'h08, 8'h15, acks);
        tests_run++; if (acks !== 3'b111) begin tests_failed++; $display("FAIL write_acks: got %b expected 111", acks); end
        tests_run++; if (oen_rises - o0 != 3) begin tests_failed++; $display("FAIL write_oen_pulses: got %0d expected 3", oen_rises - o0); end
        tests_run++; if (wr_cnt - w0 != 1 || err_cnt - e0 != 0) begin tests_failed++; $display("FAIL write_counts: got wr=%0d err=%0d expected 1 0", wr_cnt - w0, err_cnt - e0); end
        tests_run++; if (o_reg_addr !== 7'h04 || o_reg_data !== 9'h015) begin tests_failed++; $display("FAIL write_regout: got %h/%h expected 04/015", o_reg_addr, o_reg_data); end
        rd(4'd4, v);
        tests_run++; if (v !== 9'h015) begin tests_failed++; $display("FAIL write_shadow4: got %h expected 015", v); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL write_idle: got busy=%b expected 0", o_busy); end
        $display("[TB] write 34 08 15 acks=%b reg=%h data=%h", acks, o_reg_addr, o_reg_data);
    endtask

    task automatic test_wrong_addr();
        logic [2:0] acks;
        int w0, e0, o0;
        w0 = wr_cnt; e0 = err_cnt; o0 = oen_rises;
        send_frame(8'h36, 8'h0C, 8'h55, acks);
        tests_run++; if (acks !== 3'b000 || oen_rises != o0) begin tests_failed++; $display("FAIL wrongaddr_ack: got acks=%b oen_pulses=%0d expected 000 0", acks, oen_rises - o0); end
        tests_run++; if (wr_cnt != w0 || err_cnt != e0) begin tests_failed++; $display("FAIL wrongaddr_counts: got wr=%0d err=%0d expected 0 0", wr_cnt - w0, err_cnt - e0); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL wrongaddr_idle: got busy=%b expected 0", o_busy); end
        $display("[TB] frame to 0x36 acks=%b", acks);
    endtask

    task automatic test_read_rw();
        logic ack;
        int w0, e0, o0;
        w0 = wr_cnt; e0 = err_cnt; o0 = oen_rises;
        i2c_start();
        send_byte(8'h35, ack);
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL rw_nack: got ack=%b expected 0", ack); end
        tests_run++; if (o_busy !== 1'b1) begin tests_failed++; $display("FAIL rw_busy_waitstop: got %b expected 1", o_busy); end
        send_byte(8'h08, ack);
        i2c_stop();
        tests_run++; if (oen_rises != o0 || wr_cnt != w0 || err_cnt != e0) begin tests_failed++; $display("FAIL rw_ignored: got oen=%0d wr=%0d err=%0d expected 0 0 0", oen_rises - o0, wr_cnt - w0, err_cnt - e0); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL rw_idle: got busy=%b expected 0", o_busy); end
        $display("[TB] frame to 0x35 (read) ignored");
    endtask

    task automatic test_abort();
        logic ack;
        logic [2:0] acks;
        logic [8:0] v;
        int w0, e0;
        w0 = wr_cnt; e0 = err_cnt;
        i2c_start();
        send_byte(8'h34, ack);
        for (int i = 7; i >= 4; i--) send_bit(i % 2 == 0);
        i2c_stop();
        tests_run++; if (err_cnt - e0 != 1 || wr_cnt != w0) begin tests_failed++; $display("FAIL abort_counts: got err=%0d wr=%0d expected 1 0", err_cnt - e0, wr_cnt - w0); end
        tests_run++; if (o_sda_oen !== 1'b0 || o_busy !== 1'b0) begin tests_failed++; $display("FAIL abort_state: got oen=%b busy=%b expected 0 0", o_sda_oen, o_busy); end
        rd(4'd4, v);
        tests_run++; if (v !== 9'h015) begin tests_failed++; $display("FAIL abort_shadow4: got %h expected 015", v); end
        send_frame(8'h34, 8'h02, 8'hAA, acks);
        rd(4'd1, v);
        tests_run++; if (acks !== 3'b111 || wr_cnt - w0 != 1 || v !== 9'h0AA) begin tests_failed++; $display("FAIL abort_recover: got acks=%b wr=%0d shadow1=%h expected 111 1 0aa", acks, wr_cnt - w0, v); end
        $display("[TB] stop inside byte 1 -> err=%0d, recovery write shadow1=%h", err_cnt - e0, v);
    endtask

    task automatic test_out_of_range();
        logic [2:0] acks;
        logic [8:0] v;
        int w0;
        w0 = wr_cnt;
        send_frame(8'h34, 8'h1F, 8'hFF, acks);
        tests_run++; if (acks !== 3'b111 || wr_cnt - w0 != 1) begin tests_failed++; $display("FAIL oor_ack: got acks=%b wr=%0d expected 111 1", acks, wr_cnt - w0); end
        tests_run++; if (o_reg_addr !== 7'h0F || o_reg_data !== 9'h1FF) begin tests_failed++; $display("FAIL oor_regout: got %h/%h expected 0f/1ff", o_reg_addr, o_reg_data); end
        rd(4'd15, v);
        tests_run++; if (v !== 9'h000) begin tests_failed++; $display("FAIL oor_rd15: got %h expected 000", v); end
        rd(4'd4, v);
        tests_run++; if (v !== 9'h015) begin tests_failed++; $display("FAIL oor_shadow4: got %h expected 015", v); end
        $display("[TB] write reg 15 data 1ff acks=%b", acks);
    endtask

    task automatic test_back_to_back();
        logic [2:0] a0, a1;
        logic [8:0] v;
        int w0, e0;
        w0 = wr_cnt; e0 = err_cnt;
        i2c_start();
        send_byte(8'h34, a0[2]); send_byte(8'h02, a0[1]); send_byte(8'h33, a0[0]);
        i2c_start();
        send_byte(8'h34, a1[2]); send_byte(8'h0D, a1[1]); send_byte(8'h44, a1[0]);
        i2c_stop();
        tests_run++; if (a0 !== 3'b111 || a1 !== 3'b111 || wr_cnt - w0 != 2 || err_cnt != e0) begin tests_failed++; $display("FAIL b2b_counts: got acks=%b/%b wr=%0d err=%0d expected 111/111 2 0", a0, a1, wr_cnt - w0, err_cnt - e0); end
        rd(4'd6, v);
        tests_run++; if (v !== 9'h144) begin tests_failed++; $display("FAIL b2b_shadow6: got %h expected 144", v); end
        rd(4'd1, v);
        tests_run++; if (v !== 9'h033) begin tests_failed++; $display("FAIL b2b_shadow1: got %h expected 033", v); end
        $display("[TB] repeated-start pair committed wr=%0d", wr_cnt - w0);
    endtask

    task automatic test_reset_midframe();
        logic ack;
        logic [2:0] acks;
        logic [8:0] v;
        logic [6:0] init_reg [7];
        logic [8:0] init_dat [7];
        logic [8:0] exp_shadow [16];
        int w0;
        init_reg = '{POWER_DOWN, LEFT_LINE_IN, LEFT_HP_OUT, ANALOG_PATH, DIGITAL_PATH, DIGITAL_IF, ACTIVE};
        init_dat = '{9'h067, 9'h117, 9'h179, 9'h012, 9'h006, 9'h00A, 9'h001};
        exp_shadow = '{9'h117, 9'h000, 9'h179, 9'h000, 9'h012, 9'h006, 9'h067, 9'h00A,
                       9'h000, 9'h001, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, ack);
        send_byte(8'h08, ack);
        for (int i = 7; i >= 0; i--) send_bit(i % 2 == 1);
        wait_clk(8); m_sda = 1'b1; wait_clk(8); m_scl = 1'b1; wait_clk(4);
        tests_run++; if (o_sda_oen !== 1'b1) begin tests_failed++; $display("FAIL midrst_pre_oen: got %b expected 1", o_sda_oen); end
        i_rst = 1'b1;
        wait_clk(1);
        tests_run++; if (o_sda_oen !== 1'b0 || o_busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_state: got oen=%b busy=%b expected 0 0", o_sda_oen, o_busy); end
        i_rst = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), v);
            tests_run++; if (v !== 9'h000) begin tests_failed++; $display("FAIL midrst_shadow%0d: got %h expected 000", i, v); end
        end
        tests_run++; if (wr_cnt != w0) begin tests_failed++; $display("FAIL midrst_nocommit: got wr=%0d expected 0", wr_cnt - w0); end
        w0 = wr_cnt;
        for (int k = 0; k < 7; k++) begin
            send_frame(8'h34, {init_reg[k], init_dat[k][8]}, init_dat[k][7:0], acks);
            tests_run++; if (acks !== 3'b111 || o_reg_addr !== init_reg[k] || o_reg_data !== init_dat[k]) begin tests_failed++; $display("FAIL init_frame%0d: got acks=%b reg=%h data=%h expected 111 %h %h", k, acks, o_reg_addr, o_reg_data, init_reg[k], init_dat[k]); end
            $display("[TB] init frame %0d reg=%h data=%h acks=%b", k, o_reg_addr, o_reg_data, acks);
        end
        tests_run++; if (wr_cnt - w0 != 7) begin tests_failed++; $display("FAIL init_wr_count: got %0d expected 7", wr_cnt - w0); end
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), v);
            tests_run++; if (v !== exp_shadow[i]) begin tests_failed++; $display("FAIL init_shadow%0d: got %h expected %h", i, v, exp_shadow[i]); end
        end
    endtask

    initial begin
        i_rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; i_rd_addr = 4'd0;
        test_reset();
        test_write();
        test_wrong_addr();
        test_read_rw();
        test_abort();
        test_out_of_range();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
